// File: rtl/decrypt_stream.sv
// Streaming decrypt: XOR with a rotating key slot, then inverse bit permutation.
// Two-stage valid/ready pipeline with runtime-loadable keys, permutation and rotation rate.
module decrypt_stream #(
  parameter int DW    = 8,
  parameter int NKEYS = 3,
  parameter int ROT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [NKEYS*DW-1:0]   k_in,
  input  logic [DW*$clog2(DW)-1:0] perm,
  input  logic [ROT_W-1:0]      rot_freq,
  output logic                  cfg_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data
);

  localparam int PW = $clog2(DW);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [KW-1:0]    KP_LAST = KW'(NKEYS - 1);
  localparam logic [KW-1:0]    KP_ONE  = KW'(1'b1);
  localparam logic [ROT_W-1:0] ROT_ONE = ROT_W'(1'b1);

  function automatic logic [DW-1:0] inv_perm(input logic [DW-1:0] x, input logic [DW*PW-1:0] p);
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < DW; i++) begin
      y[p[i*PW +: PW]] = x[i];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] key_pick(input logic [NKEYS*DW-1:0] k, input logic [KW-1:0] idx);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < NKEYS; j++) begin
      if (idx == KW'(j)) begin
        r = k[j*DW +: DW];
      end
    end
    return r;
  endfunction

  logic [NKEYS*DW-1:0] key_r;
  logic [DW*PW-1:0]    perm_r;
  logic [ROT_W-1:0]    rot_freq_r;
  logic [KW-1:0]       kp_r;
  logic [ROT_W-1:0]    bc_r;
  logic                v1_r;
  logic [DW-1:0]       d1_r;
  logic                v2_r;
  logic [DW-1:0]       m_data_r;
  logic                cfg_err_r;
  logic                alive_r;

  logic                adv2_s;
  logic                s_ready_s;
  logic                s_fire_s;
  logic                cfg_ok_s;
  logic [KW-1:0]       kp_next_s;
  logic [ROT_W-1:0]    bc_next_s;

  // Handshake and config-acceptance decode; alive_r keeps s_ready low until the first edge after reset
  always_comb begin
    adv2_s    = !v2_r || m_ready;
    s_ready_s = alive_r && !cfg_load && !(v1_r && v2_r && !m_ready);
    s_fire_s  = s_valid && s_ready_s;
    cfg_ok_s  = cfg_load && !v1_r && !v2_r;
  end

  // Key-rotation step applied on each accepted beat
  always_comb begin
    kp_next_s = kp_r;
    bc_next_s = bc_r;
    if (rot_freq_r == '0) begin
      kp_next_s = kp_r;
      bc_next_s = bc_r;
    end else if (bc_r == rot_freq_r - ROT_ONE) begin
      bc_next_s = '0;
      if (kp_r == KP_LAST) begin
        kp_next_s = '0;
      end else begin
        kp_next_s = kp_r + KP_ONE;
      end
    end else begin
      bc_next_s = bc_r + ROT_ONE;
    end
  end

  // Config registers, key pointer and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r      <= '0;
      perm_r     <= '0;
      rot_freq_r <= '0;
      kp_r       <= '0;
      bc_r       <= '0;
      cfg_err_r  <= 1'b0;
      alive_r    <= 1'b0;
    end else begin
      alive_r   <= 1'b1;
      cfg_err_r <= cfg_load && (v1_r || v2_r);
      if (cfg_ok_s) begin
        key_r      <= k_in;
        perm_r     <= perm;
        rot_freq_r <= rot_freq;
        kp_r       <= '0;
        bc_r       <= '0;
      end else if (s_fire_s) begin
        kp_r <= kp_next_s;
        bc_r <= bc_next_s;
      end
    end
  end

  // Pipeline: stage 1 holds the XORed beat, stage 2 the permuted plaintext
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r     <= 1'b0;
      d1_r     <= '0;
      v2_r     <= 1'b0;
      m_data_r <= '0;
    end else begin
      if (adv2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          m_data_r <= inv_perm(d1_r, perm_r);
        end
      end
      if (s_fire_s) begin
        v1_r <= 1'b1;
        d1_r <= s_data ^ key_pick(key_r, kp_r);
      end else if (adv2_s) begin
        v1_r <= 1'b0;
      end
    end
  end

  assign s_ready = s_ready_s;
  assign m_valid = v2_r;
  assign m_data  = m_data_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_decrypt_stream.sv
// Randomised and directed bench for decrypt_stream against a key-schedule/permutation model.
module tb_decrypt_stream;

  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [23:0] k_in;
  logic [23:0] perm;
  logic [2:0]  rot_freq;
  logic        cfg_err;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;

  int vectors = 0;
  int miscompares = 0;

  // model config (m*) and pending config for the next cfg_load (n*)
  logic [7:0] mkey[NK];
  int         mperm[8];
  int         mrf;
  int         mn;
  logic [7:0] nkey[NK];
  int         nperm[8];
  int         nrf;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] lit_q[$];
  logic [7:0] pt_q[$];

  decrypt_stream #(.DW(8), .NKEYS(3), .ROT_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .k_in(k_in), .perm(perm),
    .rot_freq(rot_freq), .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Key slot for the n-th beat since config, then invert the permutation
  function automatic logic [7:0] dec_model(input logic [7:0] c);
    logic [7:0] x;
    logic [7:0] p;
    int ki;
    ki = (mrf == 0) ? 0 : (mn / mrf) % NK;
    x = c ^ mkey[ki];
    p = 8'h00;
    for (int i = 0; i < 8; i++) p[mperm[i]] = x[i];
    return p;
  endfunction

  function automatic logic [7:0] enc_model(input logic [7:0] p, input logic [7:0] k);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = p[mperm[i]];
    return x ^ k;
  endfunction

  // Scoreboard: outputs checked and inputs modelled on the quiet clock phase
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", {31'd0, m_valid}, 32'd0);
        else check("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        if (lit_q.size() > 0) check("lit", {24'd0, m_data}, {24'd0, lit_q.pop_front()});
        if (pt_q.size() > 0) check("roundtrip", {24'd0, m_data}, {24'd0, pt_q.pop_front()});
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(dec_model(s_data));
        mn++;
      end
    end
  end

  task automatic cfg(input bit expect_ok);
    k_in = {nkey[2], nkey[1], nkey[0]};
    for (int i = 0; i < 8; i++) perm[i*3 +: 3] = 3'(nperm[i]);
    rot_freq = 3'(nrf);
    cfg_load = 1'b1;
    @(negedge clk);
    check("cfg_sready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    if (expect_ok) begin
      for (int j = 0; j < NK; j++) mkey[j] = nkey[j];
      for (int i = 0; i < 8; i++) mperm[i] = nperm[i];
      mrf = nrf;
      mn = 0;
    end
    @(negedge clk);
    check("cfg_err", {31'd0, cfg_err}, expect_ok ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("cfg_err_clr", {31'd0, cfg_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  // mode 0: steady, 1: random valid/ready, 2: m_ready low for stall_n cycles
  task automatic run(input int mode, input int stall_n, input int budget);
    int c;
    bit fired;
    logic [7:0] held;
    c = 0;
    held = 8'h00;
    while (tx_q.size() > 0 && c < budget) begin
      s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = tx_q[0];
      if (mode == 1) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = !(mode == 2 && c < stall_n);
      @(negedge clk);
      fired = s_valid && s_ready;
      if (mode == 2 && c == 2) begin
        check("stall_sready", {31'd0, s_ready}, 32'd0);
        check("stall_mvalid", {31'd0, m_valid}, 32'd1);
        held = m_data;
      end
      if (mode == 2 && c == 3) check("stall_hold", {24'd0, m_data}, {24'd0, held});
      @(posedge clk); #1;
      if (fired) void'(tx_q.pop_front());
      c++;
    end
    s_valid = 1'b0;
    check("send_timeout", tx_q.size(), 32'd0);
  endtask

  task automatic drain();
    int c;
    c = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() > 0 || m_valid) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain", exp_q.size(), 32'd0);
    check("lit_left", lit_q.size(), 32'd0);
  endtask

  task automatic set_keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int rf);
    nkey[0] = a; nkey[1] = b; nkey[2] = c;
    for (int i = 0; i < 8; i++) nperm[i] = i;
    nrf = rf;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; k_in = '0; perm = '0; rot_freq = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int j = 0; j < NK; j++) mkey[j] = 8'h00;
    for (int i = 0; i < 8; i++) mperm[i] = 0;
    mrf = 0; mn = 0;

    // reset state and first s_ready
    @(negedge clk);
    check("rst_mvalid", {31'd0, m_valid}, 32'd0);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
    check("rst_cfgerr", {31'd0, cfg_err}, 32'd0);
    check("rst_mdata", {24'd0, m_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_sready0", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_sready1", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // rot_freq=1 with first-beat latency
    set_keys(8'h3C, 8'hA5, 8'h0F, 1);
    cfg(1'b1);
    lit_q = '{8'h3C, 8'hA5, 8'h0F, 8'h3C};
    s_valid = 1'b1; s_data = 8'h00; m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("lat_mvalid0", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_mvalid1", {31'd0, m_valid}, 32'd1);
    @(posedge clk); #1;
    tx_q = '{8'h00, 8'h00, 8'h00};
    run(0, 0, 50);
    drain();

    // rot_freq=2 and rot_freq=0
    set_keys(8'h3C, 8'hA5, 8'h0F, 2);
    cfg(1'b1);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    lit_q = '{8'h3C, 8'h3C, 8'hA5, 8'hA5, 8'h0F, 8'h0F};
    run(0, 0, 50);
    drain();
    set_keys(8'h3C, 8'hA5, 8'h0F, 0);
    cfg(1'b1);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    lit_q = '{8'h3C, 8'h3C, 8'h3C, 8'h3C};
    run(0, 0, 50);
    drain();

    // reversed permutation, zero keys
    set_keys(8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 8; i++) nperm[i] = 7 - i;
    cfg(1'b1);
    tx_q = '{8'h01, 8'hC3};
    lit_q = '{8'h80, 8'hC3};
    run(0, 0, 50);
    drain();

    // backpressure: four back-to-back beats, consumer stalled for 3 cycles
    set_keys(8'h3C, 8'hA5, 8'h0F, 1);
    cfg(1'b1);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    lit_q = '{8'h3C, 8'hA5, 8'h0F, 8'h3C};
    run(2, 3, 50);
    drain();

    // rejected cfg_load while a beat sits in stage 1
    set_keys(8'h3C, 8'hA5, 8'h0F, 1);
    cfg(1'b1);
    tx_q = '{8'h00};
    lit_q = '{8'h3C, 8'hA5, 8'h0F};
    run(0, 0, 10);
    set_keys(8'h11, 8'h22, 8'h33, 0);
    cfg(1'b0);
    tx_q = '{8'h00, 8'h00};
    run(0, 0, 50);
    drain();

    // cfg_load on an empty pipe with s_valid high: new keys from the next accept
    set_keys(8'h11, 8'h22, 8'h33, 0);
    s_valid = 1'b1; s_data = 8'h00; m_ready = 1'b1;
    lit_q = '{8'h11, 8'h11};
    cfg(1'b1);
    s_valid = 1'b0;
    drain();

    // random round-trip against the encrypt model
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < NK; j++) nkey[j] = 8'($urandom);
      for (int i = 0; i < 8; i++) nperm[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = nperm[i]; nperm[i] = nperm[j]; nperm[j] = t;
      end
      nrf = (r == 0) ? $urandom_range(1, 7) : $urandom_range(0, 7);
      cfg(1'b1);
      for (int i = 0; i < 128; i++) begin
        logic [7:0] p;
        int ki;
        p = 8'($urandom);
        ki = (mrf == 0) ? 0 : (i / mrf) % NK;
        tx_q.push_back(enc_model(p, mkey[ki]));
        pt_q.push_back(p);
      end
      run(1, 0, 3000);
      drain();
      check("pt_left", pt_q.size(), 32'd0);
    end

    // reset with two beats in flight
    set_keys(8'h3C, 8'hA5, 8'h0F, 1);
    cfg(1'b1);
    tx_q = '{8'h00, 8'h00};
    run(2, 100, 20);
    check("pre_rst_mvalid", {31'd0, m_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mvalid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_sready", {31'd0, s_ready}, 32'd0);
    exp_q.delete(); lit_q.delete(); pt_q.delete();
    for (int j = 0; j < NK; j++) mkey[j] = 8'h00;
    for (int i = 0; i < 8; i++) mperm[i] = 0;
    mrf = 0; mn = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_mvalid", {31'd0, m_valid}, 32'd0);
    end
    check("post_rst_cfgerr", {31'd0, cfg_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
